// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider, unsigned/signed, one quotient bit per clock.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module div_unit #(
    parameter int N_BIT = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             signed_in,
    input  logic [N_BIT-1:0] dividend_in,
    input  logic [N_BIT-1:0] divisor_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [N_BIT-1:0] quot_out,
    output logic [N_BIT-1:0] rem_out,
    output logic             div_zero_out
);

    localparam int CW = $clog2(N_BIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [N_BIT-1:0] acc_q, acc_d;
    logic [N_BIT-1:0] prem_q, prem_d;
    logic [N_BIT-1:0] dvs_q, dvs_d;
    logic [N_BIT-1:0] orig_q, orig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic [N_BIT-1:0] quot_q, quot_d;
    logic [N_BIT-1:0] remo_q, remo_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [N_BIT-1:0] a_mag, b_mag;
    logic [N_BIT:0]   shifted, trial;
    logic             trial_ok;

    // Negating the most negative value wraps to itself, which read unsigned is the exact magnitude.
    assign a_mag = (signed_in && dividend_in[N_BIT-1]) ? (~dividend_in + 1'b1) : dividend_in;
    assign b_mag = (signed_in && divisor_in[N_BIT-1])  ? (~divisor_in + 1'b1)  : divisor_in;

    // Partial remainder stays below the divisor, so the N_BIT+1 bit difference sign is exact.
    assign shifted  = {prem_q, acc_q[N_BIT-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign trial_ok = ~trial[N_BIT];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        prem_d  = prem_q;
        dvs_d   = dvs_q;
        orig_d  = orig_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    acc_d   = a_mag;
                    prem_d  = '0;
                    dvs_d   = b_mag;
                    orig_d  = dividend_in;
                    qneg_d  = signed_in & (dividend_in[N_BIT-1] ^ divisor_in[N_BIT-1]);
                    rneg_d  = signed_in & dividend_in[N_BIT-1];
                    zero_d  = (divisor_in == '0);
                    cnt_d   = CW'(N_BIT);
                    state_d = S_CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (divisor_in == '0) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_CALC: begin
                acc_d  = {acc_q[N_BIT-2:0], trial_ok};
                prem_d = trial_ok ? trial[N_BIT-1:0] : shifted[N_BIT-1:0];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (zero_q) begin
                    quot_d = '1;
                    remo_d = orig_q;
                    dz_d   = 1'b1;
                end else begin
                    quot_d = qneg_q ? (~acc_q + 1'b1) : acc_q;
                    remo_d = rneg_q ? (~prem_q + 1'b1) : prem_q;
                    dz_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            orig_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            prem_q  <= prem_d;
            dvs_q   <= dvs_d;
            orig_q  <= orig_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign quot_out     = quot_q;
    assign rem_out      = remo_q;
    assign div_zero_out = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit (N_BIT = 8).
module tb_div_unit;

    localparam int N = 8;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = N + 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sgn;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy_out;
    logic         done_out;
    logic [N-1:0] quot_out;
    logic [N-1:0] rem_out;
    logic         div_zero_out;

    div_unit #(.N_BIT(N)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .start_in    (start),
        .signed_in   (sgn),
        .dividend_in (a),
        .divisor_in  (b),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .quot_out    (quot_out),
        .rem_out     (rem_out),
        .div_zero_out(div_zero_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           t0;
        int           lat;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        int   xi, yi, qi, ri;
        e.t0  = 0;
        e.lat = (y == 0) ? ZLAT : N + 1;
        if (y == 0) begin
            e.q  = '1;
            e.r  = x;
            e.dz = 1'b1;
        end else begin
            if (s) begin
                xi = int'($signed(x));
                yi = int'($signed(y));
            end else begin
                xi = int'(x);
                yi = int'(y);
            end
            qi   = xi / yi;
            ri   = xi % yi;
            e.q  = qi[N-1:0];
            e.r  = ri[N-1:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic push_exp(input logic s, input logic [N-1:0] x, input logic [N-1:0] y);
        exp_t e;
        e    = model(s, x, y);
        e.t0 = cyc;
        sb.push_back(e);
    endtask

    // Drives one start pulse; returns #1 after the accepting edge.
    task automatic issue(input logic s, input logic [N-1:0] x, input logic [N-1:0] y, input bit expect_result);
        @(negedge clk);
        start = 1'b1;
        sgn   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_result) push_exp(s, x, y);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (sb.size() != 0 || busy_out); i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done_out) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("quot", quot_out, e.q);
                check("rem", rem_out, e.r);
                check("div_zero", div_zero_out, e.dz);
                check("latency", cyc - e.t0, e.lat);
                check("busy_at_done", busy_out, 0);
            end
        end
    end

    logic [N-1:0] vec_s [10];
    logic [N-1:0] vec_a [10];
    logic [N-1:0] vec_b [10];
    int           dones;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_quot", quot_out, 0);
        check("rst_rem", rem_out, 0);
        check("rst_dz", div_zero_out, 0);

        // 200/7 with busy/done profile across the iteration window
        issue(1'b0, 8'hC8, 8'h07, 1'b1);
        for (int k = 0; k <= N; k++) begin
            @(negedge clk);
            check("busy_run", busy_out, 1);
            check("done_early", done_out, 0);
        end
        drain();

        vec_s = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0};
        vec_a = '{8'hF9, 8'h07, 8'h80, 8'h80, 8'h2A, 8'h2A, 8'h80, 8'hFF, 8'h7F, 8'h00};
        vec_b = '{8'h02, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01, 8'h80, 8'h05};
        for (int i = 0; i < 10; i++) begin
            issue(vec_s[i][0], vec_a[i], vec_b[i], 1'b1);
            drain();
        end

        // start pulsed mid-operation must be ignored
        issue(1'b0, 8'h64, 8'h05, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h03;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // start held during the done cycle is accepted
        issue(1'b0, 8'h64, 8'h05, 1'b1);
        for (int i = 0; i < 20 && !done_out; i++) @(negedge clk);
        check("b2b_done_seen", done_out, 1);
        start = 1'b1;
        sgn   = 1'b0;
        a     = 8'h10;
        b     = 8'h03;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(1'b0, 8'h10, 8'h03);
        drain();

        // asynchronous reset mid-operation aborts without done
        issue(1'b0, 8'hC8, 8'h07, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy_out, 0);
        check("arst_done", done_out, 0);
        check("arst_quot", quot_out, 0);
        check("arst_rem", rem_out, 0);
        check("arst_dz", div_zero_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_out) dones++;
        end
        check("arst_no_done", dones, 0);
        issue(1'b0, 8'h09, 8'h02, 1'b1);
        drain();

        for (int i = 0; i < 30; i++) begin
            issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 255)), 1'b1);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
